video_ctrl_sequencer: RTL and testbench

Command sequencer that feeds the `control_op` / `control_data` inputs of the video formatter. It accepts formatter commands (palette entries, dimensions, sync timings, sprite data) through a valid/ready port and queues them in a FIFO. It presents one command at a time with fixed setup, hold and gap windows, so the formatter's two-flop input synchronizers always see stable data around each op. Single-shot ops are presented for exactly one cycle, because the formatter acts on them every cycle they are present.

---
 rtl/video_ctrl_sequencer.sv | 155 +++++++++++++++
 tb/tb_video_ctrl_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_ctrl_sequencer.sv
// Command sequencer for the video formatter control port: a FIFO of {op, data} commands
// replayed with fixed setup/hold/gap windows so the formatter's synchronizers see stable data.
module video_ctrl_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned SETUP_CYCLES   = 3,
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned GAP_CYCLES     = 3,
  parameter logic [7:0]  SINGLE_SHOT_OP = 8'd15
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [7:0]                    cmd_op,
  input  logic [31:0]                   cmd_data,
  input  logic                          flush,
  output logic [7:0]                    op_out,
  output logic [31:0]                   data_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AddrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW    = AddrW + 1;
  localparam int unsigned MaxSh     = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int unsigned MaxCycles = (MaxSh > GAP_CYCLES) ? MaxSh : GAP_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] SetupInit = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] HoldInit  = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapInit   = CntW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StActive, StGap} state_e;

  logic [39:0]        mem [FIFO_DEPTH];
  logic [AddrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0]  level_q, level_d;
  logic               push, pop, fifo_empty;
  logic [7:0]         head_op;
  logic [31:0]        head_data;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [7:0]         pend_op_q, pend_op_d;
  logic [7:0]         op_q, op_d;
  logic [31:0]        data_q, data_d;

  assign fifo_empty = (level_q == '0);
  assign cmd_ready  = (level_q != LevelW'(FIFO_DEPTH));
  assign head_op    = mem[rd_ptr_q][39:32];
  assign head_data  = mem[rd_ptr_q][31:0];

  assign push = cmd_valid && cmd_ready && !flush;
  // The last GAP cycle hands straight over to IDLE, so a pop may happen on that edge.
  assign pop  = !flush && !fifo_empty &&
                ((state_q == StIdle) || ((state_q == StGap) && (cnt_q == '0)));

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
    if (flush) level_d = '0;
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr_q] <= {cmd_op, cmd_data};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_op_d = pend_op_q;
    op_d      = op_q;
    data_d    = data_q;
    unique case (state_q)
      StIdle: state_d = StIdle;
      StSetup: begin
        if (flush) begin
          op_d    = '0;
          cnt_d   = GapInit;
          state_d = StGap;
        end else if (cnt_q == '0) begin
          op_d    = pend_op_q;
          cnt_d   = (pend_op_q == SINGLE_SHOT_OP) ? '0 : HoldInit;
          state_d = StActive;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StActive: begin
        if (flush || (cnt_q == '0)) begin
          op_d    = '0;
          cnt_d   = GapInit;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase
    // Op code 0 is consumed silently and leaves the FSM idle.
    if (pop && (head_op != '0)) begin
      data_d    = head_data;
      pend_op_d = head_op;
      cnt_d     = SetupInit;
      state_d   = StSetup;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_op_q <= '0;
      op_q      <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_op_q <= pend_op_d;
      op_q      <= op_d;
      data_q    <= data_d;
    end
  end

  assign op_out     = op_q;
  assign data_out   = data_q;
  assign fifo_level = level_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_video_ctrl_sequencer.sv
// Bench for video_ctrl_sequencer: table of single commands plus hand sequences, with an
// op_out monitor that checks emitted commands against a scoreboard queue.
module tb_video_ctrl_sequencer;

  localparam int Setup = 3;
  localparam int Hold  = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_op = '0;
  logic [31:0] cmd_data = '0;
  logic        flush = 1'b0;
  logic        cmd_ready, busy;
  logic [7:0]  op_out;
  logic [31:0] data_out;
  logic [4:0]  fifo_level;

  video_ctrl_sequencer dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .flush      (flush),
    .op_out     (op_out),
    .data_out   (data_out),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] data;
    int          len;
  } exp_t;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] data;
    int          exp_len;
    logic [31:0] exp_data;
  } vec_t;

  exp_t exp_q[$];
  int   rise_cyc[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   abort_pulse = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Drive one command and hold it until accepted; len=0 means nothing should be emitted.
  task automatic push_cmd(input logic [7:0] op, input logic [31:0] data, input int len);
    int t = 0;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    while (cmd_ready !== 1'b1) begin
      if (t >= 400) begin
        n_checks++;
        n_fail++;
        $display("FAIL push_timeout: cmd_ready low for %0d cycles, required high", t);
        cmd_valid = 1'b0;
        return;
      end
      tick();
      t++;
    end
    tick();
    cmd_valid = 1'b0;
    if (len != 0) begin
      e.op = op; e.data = data; e.len = len;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy !== 1'b0) begin
      if (t >= 400) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: busy=%0b after %0d cycles, required 0", name, busy, t);
        return;
      end
      tick();
      t++;
    end
  endtask

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // op_out monitor: sequencing rules and scoreboard compare.
  initial begin
    logic [7:0]  op_prev = '0;
    logic [7:0]  cur_op = '0;
    logic [31:0] data_prev = '0;
    int          stable = 0;
    int          pulse_len = 0;
    int          cur_len = 0;
    exp_t        e;
    forever begin
      @(negedge aclk);
      if (data_out !== data_prev) stable = 0;
      else                        stable++;
      if (op_out != 0 && op_prev != 0 && op_out != op_prev) begin
        n_checks++;
        n_fail++;
        $display("FAIL op_direct_change: got 0x%0h after 0x%0h, required 0 between", op_out,
                 op_prev);
      end
      if (op_out != 0 && op_prev == 0) begin
        rise_cyc.push_back(cyc);
        pulse_len = 1;
        cur_op = op_out;
        check("setup_stable", 64'(stable >= Setup), 64'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_op: got op 0x%0h, required no op", op_out);
          cur_len = 0;
        end else begin
          e = exp_q.pop_front();
          check("emit_op", 64'(op_out), 64'(e.op));
          check("emit_data", 64'(data_out), 64'(e.data));
          cur_len = e.len;
        end
      end else if (op_out != 0) begin
        pulse_len++;
      end else if (op_prev != 0) begin
        if (!abort_pulse && cur_len != 0) check("pulse_len", 64'(pulse_len), 64'(cur_len));
        abort_pulse = 1'b0;
      end
      op_prev = op_out;
      data_prev = data_out;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   t0;
    int   nz;
    vecs[0] = '{8'd1,   32'hA5A5_0001, Hold, 32'hA5A5_0001};
    vecs[1] = '{8'd15,  32'h5A5A_0002, 1,    32'h5A5A_0002};
    vecs[2] = '{8'd0,   32'hDEAD_BEEF, 0,    32'h5A5A_0002};
    vecs[3] = '{8'hFF,  32'h0000_0003, Hold, 32'h0000_0003};
    vecs[4] = '{8'd14,  32'hFFFF_FFFF, Hold, 32'hFFFF_FFFF};
    vecs[5] = '{8'd16,  32'h0123_4567, Hold, 32'h0123_4567};

    // Reset values
    #2 aresetn = 1'b0;
    tick();
    tick();
    check("rst_op_out", 64'(op_out), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    aresetn = 1'b1;
    tick();

    // Single command: timing of data, op window and busy
    push_cmd(8'd2, 32'h0240_02D0, Hold);
    tick();
    check("t1_data_new", 64'(data_out), 64'h0240_02D0);
    check("t1_op_setup", 64'(op_out), 64'd0);
    repeat (3) tick();
    check("t1_op_on", 64'(op_out), 64'd2);
    repeat (3) tick();
    check("t1_op_last", 64'(op_out), 64'd2);
    tick();
    check("t1_op_off", 64'(op_out), 64'd0);
    check("t1_busy_gap", 64'(busy), 64'd1);
    repeat (2) tick();
    check("t1_busy_gap_end", 64'(busy), 64'd1);
    tick();
    check("t1_busy_fall", 64'(busy), 64'd0);

    // Table of single commands
    for (int i = 0; i < 6; i++) begin
      push_cmd(vecs[i].op, vecs[i].data, vecs[i].exp_len);
      wait_idle("tbl_idle");
      check("tbl_data_after", 64'(data_out), 64'(vecs[i].exp_data));
      check("tbl_drained", 64'(exp_q.size()), 64'd0);
    end

    // Op 0 is discarded; the next command pops on the following edge
    push_cmd(8'd0, 32'hBAD0_0000, 0);
    push_cmd(8'd4, 32'h4444_0004, Hold);
    check("op0_data_kept", 64'(data_out), 64'h0123_4567);
    tick();
    check("op0_next_pop", 64'(data_out), 64'h4444_0004);
    wait_idle("op0_idle");
    check("op0_drained", 64'(exp_q.size()), 64'd0);

    // Sprite single-shot pulses: 1 cycle each, 7-cycle spacing
    rise_cyc.delete();
    for (int k = 0; k < 3; k++) push_cmd(8'd15, 32'h5900_0000 + k, 1);
    wait_idle("spr_idle");
    check("spr_count", 64'(rise_cyc.size()), 64'd3);
    if (rise_cyc.size() == 3) begin
      check("spr_spacing0", 64'(rise_cyc[1] - rise_cyc[0]), 64'd7);
      check("spr_spacing1", 64'(rise_cyc[2] - rise_cyc[1]), 64'd7);
    end

    // Push on the pop edge with five entries queued
    push_cmd(8'd3, 32'h7000_0000, Hold);
    tick();
    for (int k = 1; k <= 5; k++) push_cmd(8'd3, 32'h7000_0000 + k, Hold);
    repeat (4) tick();
    check("sim_level_before", 64'(fifo_level), 64'd5);
    push_cmd(8'd3, 32'h7000_0006, Hold);
    check("sim_level_after", 64'(fifo_level), 64'd5);
    wait_idle("sim_idle");
    check("sim_drained", 64'(exp_q.size()), 64'd0);

    // FIFO full while the FSM works through a long burst
    push_cmd(8'd1, 32'h1000_0000, Hold);
    tick();
    for (int k = 1; k <= 17; k++) push_cmd(8'(1 + (k % 14)), 32'h1000_0000 + k, Hold);
    check("full_level", 64'(fifo_level), 64'd16);
    check("full_ready", 64'(cmd_ready), 64'd0);
    t0 = cyc;
    push_cmd(8'd9, 32'h1000_0012, Hold);
    check("full_held_cycles", 64'(cyc - t0), 64'd4);
    check("full_level_refill", 64'(fifo_level), 64'd16);
    wait_idle("full_idle");
    check("full_drained", 64'(exp_q.size()), 64'd0);

    // Flush in the second ACTIVE cycle with four entries queued
    push_cmd(8'd3, 32'h3333_0000, Hold);
    tick();
    for (int k = 1; k <= 4; k++) push_cmd(8'd5, 32'h5555_0000 + k, Hold);
    check("fl_op_active", 64'(op_out), 64'd3);
    check("fl_level_before", 64'(fifo_level), 64'd4);
    abort_pulse = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
    check("fl_op_off", 64'(op_out), 64'd0);
    check("fl_level", 64'(fifo_level), 64'd0);
    check("fl_data_kept", 64'(data_out), 64'h3333_0000);
    repeat (2) tick();
    check("fl_gap_busy", 64'(busy), 64'd1);
    tick();
    check("fl_idle", 64'(busy), 64'd0);
    nz = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (op_out != 0) nz++;
    end
    check("fl_no_more_ops", 64'(nz), 64'd0);

    // Asynchronous reset in the middle of ACTIVE
    push_cmd(8'd9, 32'h9999_0001, Hold);
    tick();
    push_cmd(8'd9, 32'h9999_0002, Hold);
    repeat (3) tick();
    #2;
    abort_pulse = 1'b1;
    exp_q.delete();
    aresetn = 1'b0;
    #1;
    check("ar_op_out", 64'(op_out), 64'd0);
    check("ar_data_out", 64'(data_out), 64'd0);
    check("ar_level", 64'(fifo_level), 64'd0);
    check("ar_ready", 64'(cmd_ready), 64'd1);
    check("ar_busy", 64'(busy), 64'd0);
    tick();
    aresetn = 1'b1;
    tick();
    check("ar_quiet_busy", 64'(busy), 64'd0);
    check("ar_quiet_op", 64'(op_out), 64'd0);
    push_cmd(8'd6, 32'h6666_0006, Hold);
    wait_idle("ar_resume_idle");
    check("ar_resume_data", 64'(data_out), 64'h6666_0006);
    check("ar_resume_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
